// File: rtl/somador_serial_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : somador_serial_param_if
//  Description : Start/busy/done handshake and operand/result bus of the
//                digit-serial adder/subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface somador_serial_param_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] aa;
    logic [WIDTH-1:0] bb;
    logic             ccin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ss;
    logic             ccout;
    logic             ovf;

    // Requester side: issues operations and observes results
    modport master (
        output start, sub, aa, bb, ccin,
        input  busy, done, ss, ccout, ovf
    );

    // Adder side: accepts operations and produces results
    modport slave (
        input  start, sub, aa, bb, ccin,
        output busy, done, ss, ccout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/somador_serial_param.sv
`default_nettype none
// ============================================================================
//  Module      : somador_serial_param
//  Description : Digit-serial WIDTH-bit adder/subtractor. Processes DIGIT bits
//                per clock through one registered carry, LSB digit first,
//                wrapped in a start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module somador_serial_param #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    somador_serial_param_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(STEPS) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STEPS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_last;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_carry;
    logic [DIGIT:0]     w_dsum;
    logic [WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]   r_ss;
    logic               r_ccout;
    logic               r_ovf;
    logic               r_done;

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_last   = (r_state == RUN) && (r_cnt == C_LAST);

    // One digit of A plus B' plus the stored carry; bit DIGIT is the carry-out
    assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};

    // Result assembly: new digit enters at the top, so after STEPS digits the
    // first (least significant) digit has reached bit 0.
    generate
        if (STEPS == 1) begin : g_single_step
            assign w_acc_next = w_dsum[DIGIT-1:0];
        end else begin : g_multi_step
            logic [WIDTH-1:0] r_acc;

            assign w_acc_next = {w_dsum[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};

            // Private shift register keeps partial sums off the ss output
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (r_state == RUN) begin
                    r_acc <= w_acc_next;
                end
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: IDLE waits for start, RUN leaves after the last digit
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, digit stepping and result publication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_carry <= 1'b0;
            r_ss    <= '0;
            r_ccout <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                // Subtraction is A + ~B + 1; ccin then acts as a borrow-in
                r_a     <= bus.aa;
                r_b     <= bus.sub ? ~bus.bb : bus.bb;
                r_a_msb <= bus.aa[WIDTH-1];
                r_b_msb <= bus.sub ? ~bus.bb[WIDTH-1] : bus.bb[WIDTH-1];
                r_carry <= bus.ccin ^ bus.sub;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_a     <= r_a >> DIGIT;
                r_b     <= r_b >> DIGIT;
                r_carry <= w_dsum[DIGIT];
                r_cnt   <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_ss    <= w_acc_next;
                    r_ccout <= w_dsum[DIGIT];
                    r_ovf   <= (r_a_msb == r_b_msb) && (w_dsum[DIGIT-1] != r_a_msb);
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign bus.busy  = (r_state == RUN);
    assign bus.done  = r_done;
    assign bus.ss    = r_ss;
    assign bus.ccout = r_ccout;
    assign bus.ovf   = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_somador_serial_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_somador_serial_param
//  Description : Self-checking bench for the digit-serial adder/subtractor:
//                directed cases on a 16/4 instance plus a random sweep over
//                eight WIDTH/DIGIT configurations against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_somador_serial_param;
    localparam int NCFG = 8;

    function automatic int cfg_w(int i);
        case (i)
            0, 1:    return 4;
            2, 3, 4: return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_d(int i);
        case (i)
            0, 2, 5: return 1;
            1, 3, 6: return 4;
            default: return 16;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // Directed-test instance
    somador_serial_param_if #(.WIDTH(16)) mif ();
    somador_serial_param #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (mif.slave)
    );

    // Sweep instances share one stimulus, truncated to each width
    logic            sw_start, sw_sub, sw_ccin;
    logic [31:0]     sw_aa, sw_bb;
    logic [31:0]     sw_ss [NCFG];
    logic [NCFG-1:0] sw_done, sw_busy, sw_co, sw_ov;

    generate
        for (genvar g = 0; g < NCFG; g++) begin : g_sweep
            localparam int W = cfg_w(g);
            localparam int D = cfg_d(g);
            somador_serial_param_if #(.WIDTH(W)) sif ();
            assign sif.start = sw_start;
            assign sif.sub   = sw_sub;
            assign sif.ccin  = sw_ccin;
            assign sif.aa    = sw_aa[W-1:0];
            assign sif.bb    = sw_bb[W-1:0];
            somador_serial_param #(.WIDTH(W), .DIGIT(D)) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (sif.slave)
            );
            assign sw_ss[g]   = 32'(sif.ss);
            assign sw_done[g] = sif.done;
            assign sw_busy[g] = sif.busy;
            assign sw_co[g]   = sif.ccout;
            assign sw_ov[g]   = sif.ovf;
        end
    endgenerate

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic reference: unsigned result/carry and signed range overflow
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic c,
                         output logic [31:0] ss, output logic co, output logic ov);
        longint mask = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'(a) & mask;
        longint ub   = longint'(b) & mask;
        longint sa   = (ua >= half) ? ua - 2 * half : ua;
        longint sb   = (ub >= half) ? ub - 2 * half : ub;
        longint r, t;
        if (!s) begin
            r  = ua + ub + longint'(c);
            co = (r > mask);
            t  = sa + sb + longint'(c);
        end else begin
            r  = ua - ub - longint'(c);
            co = (r >= 0);
            t  = sa - sb - longint'(c);
        end
        ss = 32'(r & mask);
        ov = (t > half - 1) || (t < -half);
    endtask

    // Issue one operation on the directed instance and wait for done
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic c, output int lat, output int bc);
        mif.aa = a; mif.bb = b; mif.sub = s; mif.ccin = c; mif.start = 1'b1;
        tick();
        mif.start = 1'b0;
        mif.aa = 16'($urandom);
        mif.bb = 16'($urandom);
        mif.sub = 1'($urandom);
        mif.ccin = 1'($urandom);
        lat = 0;
        bc  = mif.busy ? 1 : 0;
        while (!mif.done && lat < 40) begin
            tick();
            lat++;
            if (mif.busy) bc++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, cnt;
        rst = 1'b1;
        mif.start = 1'b0; mif.sub = 1'b0; mif.ccin = 1'b0; mif.aa = '0; mif.bb = '0;
        sw_start = 1'b0; sw_sub = 1'b0; sw_ccin = 1'b0; sw_aa = '0; sw_bb = '0;
        repeat (2) tick();
        check_value("rst_busy", 64'(mif.busy), 0);
        check_value("rst_done", 64'(mif.done), 0);
        check_value("rst_ss", 64'(mif.ss), 0);
        check_value("rst_ccout", 64'(mif.ccout), 0);
        check_value("rst_ovf", 64'(mif.ovf), 0);
        @(negedge clk) rst = 1'b0;
        tick();

        // Full carry ripple
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bc);
        check_value("ripple_lat", 64'(lat), 4);
        check_value("ripple_busy_cycles", 64'(bc), 4);
        check_value("ripple_busy_at_done", 64'(mif.busy), 0);
        check_value("ripple_ss", 64'(mif.ss), 64'h0000);
        check_value("ripple_ccout", 64'(mif.ccout), 1);
        check_value("ripple_ovf", 64'(mif.ovf), 0);
        tick();
        check_value("done_one_cycle", 64'(mif.done), 0);
        check_value("ss_holds", 64'(mif.ss), 64'h0000);

        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bc);
        check_value("addovf_ss", 64'(mif.ss), 64'h8000);
        check_value("addovf_ccout", 64'(mif.ccout), 0);
        check_value("addovf_ovf", 64'(mif.ovf), 1);

        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, lat, bc);
        check_value("sub_borrow_ss", 64'(mif.ss), 64'hFFFE);
        check_value("sub_borrow_ccout", 64'(mif.ccout), 0);
        check_value("sub_borrow_ovf", 64'(mif.ovf), 0);

        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, lat, bc);
        check_value("subovf_ss", 64'(mif.ss), 64'h7FFF);
        check_value("subovf_ccout", 64'(mif.ccout), 1);
        check_value("subovf_ovf", 64'(mif.ovf), 1);

        run_op(16'h0010, 16'h0001, 1'b1, 1'b1, lat, bc);
        check_value("sub_bin_ss", 64'(mif.ss), 64'h000E);

        // start during RUN is ignored
        mif.aa = 16'h1234; mif.bb = 16'h0001; mif.sub = 1'b0; mif.ccin = 1'b0; mif.start = 1'b1;
        tick();
        mif.start = 1'b0;
        tick();
        tick();
        mif.aa = 16'hFFFF; mif.bb = 16'hFFFF; mif.sub = 1'b1; mif.start = 1'b1;
        tick();
        mif.start = 1'b0;
        lat = 3;
        while (!mif.done && lat < 40) begin
            tick();
            lat++;
        end
        check_value("ignore_lat", 64'(lat), 4);
        check_value("ignore_ss", 64'(mif.ss), 64'h1235);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mif.done) cnt++;
        end
        check_value("ignore_no_extra_done", 64'(cnt), 0);

        // Back-to-back: second start lands in the done cycle
        run_op(16'h0100, 16'h0023, 1'b0, 1'b0, lat, bc);
        check_value("b2b_first_ss", 64'(mif.ss), 64'h0123);
        run_op(16'h2000, 16'h0002, 1'b1, 1'b0, lat, bc);
        check_value("b2b_lat", 64'(lat), 4);
        check_value("b2b_ss", 64'(mif.ss), 64'h1FFE);
        check_value("b2b_ccout", 64'(mif.ccout), 1);

        // Asynchronous reset between t2 and t3
        mif.aa = 16'hAAAA; mif.bb = 16'h1111; mif.sub = 1'b0; mif.start = 1'b1;
        tick();
        mif.start = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check_value("arst_busy", 64'(mif.busy), 0);
        check_value("arst_done", 64'(mif.done), 0);
        check_value("arst_ss", 64'(mif.ss), 0);
        check_value("arst_ccout", 64'(mif.ccout), 0);
        check_value("arst_ovf", 64'(mif.ovf), 0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mif.done) cnt++;
        end
        check_value("arst_no_done", 64'(cnt), 0);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat, bc);
        check_value("post_rst_lat", 64'(lat), 4);
        check_value("post_rst_ss", 64'(mif.ss), 64'h2345);

        // Random sweep across all configurations
        for (int it = 0; it < 40; it++) begin
            logic [NCFG-1:0] got;
            int              lat_g [NCFG];
            logic [31:0]     ss_g  [NCFG];
            logic [NCFG-1:0] co_g, ov_g;
            int              cyc;
            logic [31:0]     e_ss;
            logic            e_co, e_ov;

            if (it == 0) begin
                sw_aa = 32'hFFFF_FFFF; sw_bb = 32'h0; sw_sub = 1'b0; sw_ccin = 1'b1;
            end else if (it == 1) begin
                sw_aa = 32'h0; sw_bb = 32'h0; sw_sub = 1'b1; sw_ccin = 1'b1;
            end else begin
                sw_aa = $urandom; sw_bb = $urandom;
                sw_sub = 1'($urandom_range(0, 1)); sw_ccin = 1'($urandom_range(0, 1));
            end
            sw_start = 1'b1;
            tick();
            sw_start = 1'b0;
            check_value($sformatf("sw_busy_it%0d", it), 64'(sw_busy), 64'(8'hFF));
            got = '0; co_g = '0; ov_g = '0;
            for (int g = 0; g < NCFG; g++) begin
                lat_g[g] = -1;
                ss_g[g]  = '0;
            end
            cyc = 0;
            while (got != {NCFG{1'b1}} && cyc < 40) begin
                tick();
                cyc++;
                for (int g = 0; g < NCFG; g++) begin
                    if (sw_done[g] && !got[g]) begin
                        got[g]   = 1'b1;
                        lat_g[g] = cyc;
                        ss_g[g]  = sw_ss[g];
                        co_g[g]  = sw_co[g];
                        ov_g[g]  = sw_ov[g];
                    end
                end
            end
            for (int g = 0; g < NCFG; g++) begin
                model(cfg_w(g), sw_aa, sw_bb, sw_sub, sw_ccin, e_ss, e_co, e_ov);
                check_value($sformatf("sw_w%0d_d%0d_lat", cfg_w(g), cfg_d(g)),
                            64'(lat_g[g]), 64'(cfg_w(g) / cfg_d(g)));
                check_value($sformatf("sw_w%0d_d%0d_ss", cfg_w(g), cfg_d(g)), 64'(ss_g[g]), 64'(e_ss));
                check_value($sformatf("sw_w%0d_d%0d_ccout", cfg_w(g), cfg_d(g)), 64'(co_g[g]), 64'(e_co));
                check_value($sformatf("sw_w%0d_d%0d_ovf", cfg_w(g), cfg_d(g)), 64'(ov_g[g]), 64'(e_ov));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
